// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) constants: codeword/data widths and bit positions.
// Bit map: c6=d3, c5=d2, c4=d1, c3=p4, c2=d0, c1=p2, c0=p1.
package hamming74_pkg;

   localparam int CW_W   = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Data-bit positions inside the codeword
   localparam int D0_IDX = 2;
   localparam int D1_IDX = 4;
   localparam int D2_IDX = 5;
   localparam int D3_IDX = 6;

   // Parity-bit positions inside the codeword
   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int P4_IDX = 3;

   // Pull the four data bits out of a (corrected) codeword
   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
      return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
   endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome. A non-zero result k means codeword
// bit k-1 is the single flipped bit. Shared with the encoder-side checker.
module hamming74_syndrome
   import hamming74_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   output logic [SYN_W-1:0] syndrome
);

   // Each syndrome bit re-checks one parity group
   assign syndrome[0] = codeword[P1_IDX] ^ codeword[D0_IDX] ^ codeword[D1_IDX] ^ codeword[D3_IDX];
   assign syndrome[1] = codeword[P2_IDX] ^ codeword[D0_IDX] ^ codeword[D2_IDX] ^ codeword[D3_IDX];
   assign syndrome[2] = codeword[P4_IDX] ^ codeword[D1_IDX] ^ codeword[D2_IDX] ^ codeword[D3_IDX];

endmodule

// File: rtl/hamming74_decoder_stream.sv
// Two-stage streaming Hamming(7,4) decoder / single-bit corrector.
// S1 registers codeword + syndrome, S2 registers corrected data and flags.
// Double errors are miscorrected; there is no double-error flag.
// Optional statistics counters: define HAMMING_DEC_STATS_EN.
module hamming74_decoder_stream
   import hamming74_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [CW_W-1:0]   encoded_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              err_detected,
   output logic [SYN_W-1:0]  err_pos,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              clear_stats,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  corr_count
);

   logic              s1_valid_reg;
   logic [CW_W-1:0]   s1_cw_reg;
   logic [SYN_W-1:0]  s1_syn_reg;
   logic [SYN_W-1:0]  syn_next;
   logic [CW_W-1:0]   flip_mask;
   logic [CW_W-1:0]   corrected;
   logic              s2_load;

   hamming74_syndrome u_syndrome (
      .codeword (encoded_in),
      .syndrome (syn_next)
   );

   // A stage loads when empty or when its word leaves this cycle; ready is
   // the only combinational path through the pipe.
   assign s2_load  = !out_valid | out_ready;
   assign in_ready = !s1_valid_reg | s2_load;

   // One-hot flip mask: bit gi flips when the syndrome points at it
   generate
      for (genvar gi = 0; gi < CW_W; gi++) begin : g_flip
         assign flip_mask[gi] = (s1_syn_reg == SYN_W'(gi + 1));
      end
   endgenerate

   assign corrected = s1_cw_reg ^ flip_mask;

   // Stage 1: capture codeword and its syndrome on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_cw_reg    <= '0;
         s1_syn_reg   <= '0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_cw_reg  <= encoded_in;
            s1_syn_reg <= syn_next;
         end
      end
   end

   // Stage 2: corrected data and error flags; held while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         data_out     <= '0;
         err_detected <= 1'b0;
         err_pos      <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid_reg;
         if (s1_valid_reg) begin
            data_out     <= extract_data(corrected);
            err_detected <= (s1_syn_reg != '0);
            err_pos      <= s1_syn_reg;
         end
      end
   end

`ifdef HAMMING_DEC_STATS_EN
   logic [CNT_W-1:0] word_count_reg;
   logic [CNT_W-1:0] corr_count_reg;
   logic             deliver;

   assign deliver = out_valid & out_ready;

   // Saturating delivery statistics; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_count_reg <= '0;
         corr_count_reg <= '0;
      end else if (clear_stats) begin
         word_count_reg <= '0;
         corr_count_reg <= '0;
      end else if (deliver) begin
         if (word_count_reg != '1)
            word_count_reg <= word_count_reg + CNT_W'(1);
         if (err_detected && (corr_count_reg != '1))
            corr_count_reg <= corr_count_reg + CNT_W'(1);
      end
   end

   assign word_count = word_count_reg;
   assign corr_count = corr_count_reg;
`else
   logic unused_clear_stats;

   assign unused_clear_stats = clear_stats;
   assign word_count         = '0;
   assign corr_count         = '0;
`endif

endmodule
